// File: rtl/lcd_timing_ctrl_if.sv
// rtl/lcd_timing_ctrl_if.sv - control, config and video bus of lcd_timing_ctrl
// Optional frame_cnt signal exists only when LCD_TIMING_FRAME_CNT_EN is defined.
interface lcd_timing_ctrl_if #(
    parameter int CNT_W = 12
);
    logic             en;
    logic             cfg_wr;
    logic [2:0]       cfg_addr;
    logic [CNT_W-1:0] cfg_wdata;
    logic             cfg_pending;
    logic             req;
    logic [CNT_W-1:0] req_x;
    logic [CNT_W-1:0] req_y;
    logic             lcd_hs;
    logic             lcd_vs;
    logic             lcd_de;
    logic             line_start;
    logic             frame_start;
`ifdef LCD_TIMING_FRAME_CNT_EN
    logic [15:0]      frame_cnt;
`endif

    modport master (
        output en, cfg_wr, cfg_addr, cfg_wdata,
        input  cfg_pending, req, req_x, req_y, lcd_hs, lcd_vs, lcd_de,
               line_start, frame_start
`ifdef LCD_TIMING_FRAME_CNT_EN
        , input frame_cnt
`endif
    );

    modport slave (
        input  en, cfg_wr, cfg_addr, cfg_wdata,
        output cfg_pending, req, req_x, req_y, lcd_hs, lcd_vs, lcd_de,
               line_start, frame_start
`ifdef LCD_TIMING_FRAME_CNT_EN
        , output frame_cnt
`endif
    );
endinterface

// File: rtl/lcd_timing_ctrl.sv
// rtl/lcd_timing_ctrl.sv - reconfigurable LCD timing generator with prefetch request stage
// Define LCD_TIMING_FRAME_CNT_EN to add the frame_cnt output.
module lcd_timing_ctrl #(
    parameter int CNT_W    = 12,
    parameter int H_VIS_D  = 800,
    parameter int H_FP_D   = 40,
    parameter int H_SYNC_D = 4,
    parameter int H_BP_D   = 36,
    parameter int V_VIS_D  = 480,
    parameter int V_FP_D   = 12,
    parameter int V_SYNC_D = 4,
    parameter int V_BP_D   = 16,
    parameter int HS_ACT   = 0,
    parameter int VS_ACT   = 0,
    parameter int PREFETCH = 2
) (
    input logic              clk,
    input logic              rst_n,
    lcd_timing_ctrl_if.slave bus
);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic HS_ON = (HS_ACT != 0);
    localparam logic VS_ON = (VS_ACT != 0);

    function automatic cnt_t reset_val(input int i);
        case (i)
            0:       return cnt_t'(H_VIS_D);
            1:       return cnt_t'(H_FP_D);
            2:       return cnt_t'(H_SYNC_D);
            3:       return cnt_t'(H_BP_D);
            4:       return cnt_t'(V_VIS_D);
            5:       return cnt_t'(V_FP_D);
            6:       return cnt_t'(V_SYNC_D);
            default: return cnt_t'(V_BP_D);
        endcase
    endfunction

    cnt_t shadow [8];
    cnt_t active [8];
    cnt_t h_cnt, v_cnt;
    cnt_t req_x, req_y;
    logic pending;
    // Index 0 is the request stage, index PREFETCH drives the panel.
    logic [PREFETCH:0] p_hs, p_vs, p_de, p_ls, p_fs;
`ifdef LCD_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    cnt_t h_tot, v_tot, h_beg, v_beg, h_fin, v_fin, wdata_fix;
    logic h_end, v_end, h_in, v_in;

    always_comb begin
        h_beg = active[2] + active[3];
        v_beg = active[6] + active[7];
        h_fin = h_beg + active[0];
        v_fin = v_beg + active[4];
        h_tot = h_fin + active[1];
        v_tot = v_fin + active[5];
        h_end = (h_cnt == h_tot - cnt_t'(1));
        v_end = (v_cnt == v_tot - cnt_t'(1));
        h_in  = (h_cnt >= h_beg) && (h_cnt < h_fin);
        v_in  = (v_cnt >= v_beg) && (v_cnt < v_fin);
        // Visible sizes and sync widths of zero would collapse the timing; clamp to 1.
        wdata_fix = (bus.cfg_wdata == '0 && !bus.cfg_addr[0]) ? cnt_t'(1) : bus.cfg_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            pending <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= reset_val(i);
                active[i] <= reset_val(i);
            end
            p_hs  <= {(PREFETCH+1){~HS_ON}};
            p_vs  <= {(PREFETCH+1){~VS_ON}};
            p_de  <= '0;
            p_ls  <= '0;
            p_fs  <= '0;
            req_x <= '0;
            req_y <= '0;
`ifdef LCD_TIMING_FRAME_CNT_EN
            frame_cnt <= '0;
`endif
        end else begin
            if (bus.cfg_wr)
                shadow[bus.cfg_addr] <= wdata_fix;
            if (!bus.en) begin
                h_cnt   <= '0;
                v_cnt   <= '0;
                pending <= 1'b0;
                // Include this cycle's write so the restart never sees stale timing.
                for (int i = 0; i < 8; i++)
                    active[i] <= (bus.cfg_wr && bus.cfg_addr == 3'(i)) ? wdata_fix : shadow[i];
                p_hs  <= {(PREFETCH+1){~HS_ON}};
                p_vs  <= {(PREFETCH+1){~VS_ON}};
                p_de  <= '0;
                p_ls  <= '0;
                p_fs  <= '0;
                req_x <= '0;
                req_y <= '0;
`ifdef LCD_TIMING_FRAME_CNT_EN
                frame_cnt <= '0;
`endif
            end else begin
                h_cnt <= h_end ? '0 : h_cnt + cnt_t'(1);
                if (h_end)
                    v_cnt <= v_end ? '0 : v_cnt + cnt_t'(1);
                if (h_end && v_end) begin
                    for (int i = 0; i < 8; i++)
                        active[i] <= shadow[i];
                    pending <= bus.cfg_wr;
                end else if (bus.cfg_wr) begin
                    pending <= 1'b1;
                end
                p_hs[0] <= (h_cnt < active[2]) ? HS_ON : ~HS_ON;
                p_vs[0] <= (v_cnt < active[6]) ? VS_ON : ~VS_ON;
                p_de[0] <= h_in && v_in;
                p_ls[0] <= (h_cnt == '0);
                p_fs[0] <= (h_cnt == '0) && (v_cnt == '0);
                req_x   <= (h_in && v_in) ? h_cnt - h_beg : '0;
                req_y   <= (h_in && v_in) ? v_cnt - v_beg : '0;
                p_hs[PREFETCH:1] <= p_hs[PREFETCH-1:0];
                p_vs[PREFETCH:1] <= p_vs[PREFETCH-1:0];
                p_de[PREFETCH:1] <= p_de[PREFETCH-1:0];
                p_ls[PREFETCH:1] <= p_ls[PREFETCH-1:0];
                p_fs[PREFETCH:1] <= p_fs[PREFETCH-1:0];
`ifdef LCD_TIMING_FRAME_CNT_EN
                // Counts on the edge that loads frame_start, so both appear together.
                frame_cnt <= frame_cnt + 16'(p_fs[PREFETCH-1]);
`endif
            end
        end
    end

    assign bus.cfg_pending = pending;
    assign bus.req         = p_de[0];
    assign bus.req_x       = req_x;
    assign bus.req_y       = req_y;
    assign bus.lcd_hs      = p_hs[PREFETCH];
    assign bus.lcd_vs      = p_vs[PREFETCH];
    assign bus.lcd_de      = p_de[PREFETCH];
    assign bus.line_start  = p_ls[PREFETCH];
    assign bus.frame_start = p_fs[PREFETCH];
`ifdef LCD_TIMING_FRAME_CNT_EN
    assign bus.frame_cnt   = frame_cnt;
`endif
endmodule
